sng_array: RTL and testbench

// - Multi-channel stochastic number generator: converts N binary operands into N parallel

---
 rtl/sng_pkg.sv | 44 ++++
 rtl/sng_lfsr.sv | 24 ++
 rtl/sng_array.sv | 111 +++++++++++
 tb/tb_sng_array.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sng_pkg.sv
// Shared types and helpers for the stochastic number generator array.
// Tap masks are for a shift-left Fibonacci LFSR whose feedback enters bit 0.
package sng_pkg;

  typedef enum logic {IDLE, RUN} sng_state_e;

  // Maximal-length feedback masks; bit (t-1) set for tap t.
  function automatic logic [15:0] lfsr_taps(input int w);
    logic [15:0] m;
    case (w)
      3:       m = 16'h0006;
      4:       m = 16'h000C;
      5:       m = 16'h0014;
      6:       m = 16'h0030;
      7:       m = 16'h0060;
      8:       m = 16'h00B8;
      9:       m = 16'h0110;
      10:      m = 16'h0240;
      11:      m = 16'h0500;
      12:      m = 16'h0829;
      13:      m = 16'h100D;
      14:      m = 16'h2015;
      15:      m = 16'h6000;
      16:      m = 16'hD008;
      default: m = 16'h000C;
    endcase
    return m;
  endfunction

  // Rotate the low w bits of v left by c; bits at or above w come back zero.
  function automatic logic [15:0] rotl(input logic [15:0] v, input int w, input int c);
    logic [15:0] r;
    logic [3:0]  idx;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < w) begin
        idx    = 4'((i + c) % w);
        r[idx] = v[4'(i)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sng_lfsr.sv
// W-bit maximal-length Fibonacci LFSR; loads SEED on reset or i_load, steps on i_en.
module sng_lfsr import sng_pkg::*; #(
  parameter int             W    = 4,
  parameter logic [W-1:0]   SEED = W'(1)
) (
  input  logic         i_clk_sng,
  input  logic         i_rst_sng,
  input  logic         i_load,
  input  logic         i_en,
  output logic [W-1:0] o_lfsr
);

  localparam logic [15:0]  TAPS_ALL = lfsr_taps(W);
  localparam logic [W-1:0] TAPS     = TAPS_ALL[W-1:0];

  always_ff @(posedge i_clk_sng) begin
    if (i_rst_sng || i_load) begin
      o_lfsr <= SEED;
    end else if (i_en) begin
      o_lfsr <= {o_lfsr[W-2:0], ^(o_lfsr & TAPS)};
    end
  end

endmodule

// File: rtl/sng_array.sv
// N-channel stochastic number generator: one registered bit per channel per RUN cycle,
// STREAM_LEN cycles per stream, abortable; all outputs registered.
module sng_array import sng_pkg::*; #(
  parameter int           W          = 4,
  parameter int           N          = 4,
  parameter int           STREAM_LEN = 2**W - 1,
  parameter logic [W-1:0] SEED       = W'(1)
) (
  input  logic           i_clk_sng,
  input  logic           i_rst_sng,
  input  logic [N*W-1:0] i_x_bn,
  input  logic           i_mode_bp,
  input  logic           i_start_sng,
  input  logic           i_stop_sng,
  output logic [N-1:0]   o_sn_bits,
  output logic           o_sn_valid,
  output logic           o_done,
  output logic           o_busy
);

  localparam int            CW   = $clog2(STREAM_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(STREAM_LEN - 1);

  sng_state_e     state, state_nxt;
  logic           load, run, last, emit;
  logic [CW-1:0]  cnt;
  logic [N*W-1:0] x_q;
  logic           mode_q;
  logic [W-1:0]   lfsr;
  logic [15:0]    lfsr_ext;
  logic [N-1:0]   cmp;

  assign last = (cnt == LAST);
  assign emit = run && !i_stop_sng;

  always_ff @(posedge i_clk_sng) begin
    if (i_rst_sng) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    run       = 1'b0;
    case (state)
      IDLE: begin
        if (i_start_sng && !i_stop_sng) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        run = 1'b1;
        if (i_stop_sng || last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk_sng) begin
    if (i_rst_sng) begin
      x_q        <= '0;
      mode_q     <= 1'b0;
      cnt        <= '0;
      o_sn_bits  <= '0;
      o_sn_valid <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_sn_valid <= emit;
      o_sn_bits  <= emit ? cmp : '0;
      o_done     <= emit && last;
      if (load) begin
        x_q    <= i_x_bn;
        mode_q <= i_mode_bp;
        cnt    <= '0;
      end else if (run) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign o_busy = (state == RUN);

  sng_lfsr #(.W(W), .SEED(SEED)) u_lfsr (
    .i_clk_sng (i_clk_sng),
    .i_rst_sng (i_rst_sng),
    .i_load    (load),
    .i_en      (run),
    .o_lfsr    (lfsr)
  );

  always_comb begin
    lfsr_ext         = '0;
    lfsr_ext[W-1:0]  = lfsr;
  end

  // Bipolar offset (flip the sign bit) maps two's-complement x onto 0..2**W-1.
  for (genvar c = 0; c < N; c++) begin : g_ch
    logic [W-1:0] xc, xu;
    logic [15:0]  xu_ext, rot;
    assign xc  = x_q[c*W +: W];
    assign xu  = mode_q ? {~xc[W-1], xc[W-2:0]} : xc;
    assign rot = rotl(lfsr_ext, W, c);
    always_comb begin
      xu_ext        = '0;
      xu_ext[W-1:0] = xu;
    end
    assign cmp[c] = (rot <= xu_ext) && (xu_ext != '0);
  end

endmodule

// File: tb/tb_sng_array.sv
// Bench for sng_array: table vectors, random operands against a ones-count model,
// and hand sequences for abort, reset, ignored start and the long-stream instance.
module tb_sng_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, stop, mode;
  logic [15:0] x;
  logic [3:0]  bits;
  logic        valid, done, busy;

  logic        start1;
  logic [3:0]  x1;
  logic [0:0]  bits1;
  logic        valid1, done1, busy1;

  sng_array #(.W(4), .N(4), .STREAM_LEN(15), .SEED(4'd1)) dut (
    .i_clk_sng(clk), .i_rst_sng(rst), .i_x_bn(x), .i_mode_bp(mode),
    .i_start_sng(start), .i_stop_sng(stop), .o_sn_bits(bits),
    .o_sn_valid(valid), .o_done(done), .o_busy(busy)
  );

  sng_array #(.W(4), .N(1), .STREAM_LEN(30), .SEED(4'd1)) dut_long (
    .i_clk_sng(clk), .i_rst_sng(rst), .i_x_bn(x1), .i_mode_bp(1'b0),
    .i_start_sng(start1), .i_stop_sng(1'b0), .o_sn_bits(bits1),
    .o_sn_valid(valid1), .o_done(done1), .o_busy(busy1)
  );

  int total = 0;
  int bad   = 0;

  // Cumulative observations; tests work on differences from a snapshot.
  int         vcnt = 0, dcnt = 0, done_at = 0;
  int         ones[4] = '{default: 0};
  logic [3:0] bitq[$];
  int         vcnt1 = 0, dcnt1 = 0, ones1 = 0;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      vcnt++;
      for (int c = 0; c < 4; c++) ones[c] += int'(bits[c]);
      bitq.push_back(bits);
    end
    if (done === 1'b1) begin
      dcnt++;
      done_at = vcnt;
    end
    if (valid1 === 1'b1) begin
      vcnt1++;
      ones1 += int'(bits1[0]);
    end
    if (done1 === 1'b1) dcnt1++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Ones per channel over one full LFSR period equals the unsigned operand;
  // bipolar operands are the signed value shifted up by half the range.
  function automatic logic [3:0][4:0] model(input logic [15:0] xv, input logic m);
    logic [3:0][4:0] r;
    for (int c = 0; c < 4; c++) begin
      int v;
      v = int'(xv[c*4 +: 4]);
      if (m) v = ((v >= 8) ? v - 16 : v) + 8;
      r[c] = 5'(v);
    end
    return r;
  endfunction

  task automatic stream(input string nm, input logic [15:0] xv, input logic m,
                        input logic [3:0][4:0] e, input int inj);
    int bv, bd;
    int bo[4];
    bv = vcnt;
    bd = dcnt;
    for (int c = 0; c < 4; c++) bo[c] = ones[c];
    x = xv; mode = m; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 60 && busy; k++) begin
      if (k == inj) begin
        x = ~xv; mode = ~m; start = 1'b1;
      end
      @(posedge clk); #1 start = 1'b0;
    end
    check({nm, "_idle"}, busy, 0);
    @(posedge clk); #1;
    check({nm, "_valid_cycles"}, vcnt - bv, 15);
    check({nm, "_done_count"}, dcnt - bd, 1);
    check({nm, "_done_pos"}, done_at - bv, 15);
    for (int c = 0; c < 4; c++)
      check($sformatf("%s_ones_ch%0d", nm, c), ones[c] - bo[c], e[c]);
  endtask

  typedef struct packed {
    logic [15:0]     x;
    logic            mode;
    logic [3:0][4:0] exp;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int b1, b2, bd;
    logic [15:0] rx;
    logic        rm;

    tbl[0] = '{x: 16'h018F, mode: 1'b0, exp: {5'd0, 5'd1, 5'd8, 5'd15}};
    tbl[1] = '{x: 16'hC807, mode: 1'b1, exp: {5'd4, 5'd0, 5'd8, 5'd15}};
    tbl[2] = '{x: 16'h4321, mode: 1'b0, exp: {5'd4, 5'd3, 5'd2, 5'd1}};
    tbl[3] = '{x: 16'h1FE9, mode: 1'b1, exp: {5'd9, 5'd7, 5'd6, 5'd1}};

    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; x = '0;
    start1 = 1'b0; x1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", valid, 0);
    check("rst_bits", bits, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_long_busy", busy1, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++)
      stream($sformatf("tbl%0d", i), tbl[i].x, tbl[i].mode, tbl[i].exp, -1);

    for (int i = 0; i < 6; i++) begin
      rx = 16'($urandom);
      rm = 1'($urandom_range(0, 1));
      stream($sformatf("rnd%0d", i), rx, rm, model(rx, rm), -1);
    end

    // Abort on the fifth valid bit.
    b1 = vcnt; bd = dcnt;
    x = tbl[0].x; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 40 && (vcnt - b1) < 5; k++) begin
      @(negedge clk); #1;
    end
    check("stop_reach5", vcnt - b1, 5);
    stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    check("stop_valid", valid, 0);
    check("stop_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check("stop_no_more_valid", vcnt - b1, 5);
    check("stop_no_done", dcnt - bd, 0);
    stream("after_stop", tbl[0].x, 1'b0, tbl[0].exp, -1);

    // A second start mid-stream with other operands must be ignored.
    stream("start_in_run", tbl[2].x, 1'b0, tbl[2].exp, 3);

    // Start and stop together in IDLE.
    b1 = vcnt;
    x = tbl[0].x; start = 1'b1; stop = 1'b1;
    @(posedge clk); #1 start = 1'b0; stop = 1'b0;
    check("start_stop_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    check("start_stop_no_valid", vcnt - b1, 0);

    // Reset on the seventh valid bit, then restart and compare sequences.
    b1 = vcnt; bd = dcnt;
    x = tbl[1].x; mode = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 40 && (vcnt - b1) < 7; k++) begin
      @(negedge clk); #1;
    end
    check("rst7_reach7", vcnt - b1, 7);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("rst7_valid", valid, 0);
    check("rst7_bits", bits, 0);
    check("rst7_done", done, 0);
    check("rst7_busy", busy, 0);
    @(posedge clk); #1;
    check("rst7_no_done", dcnt - bd, 0);
    b2 = vcnt;
    stream("restart", tbl[1].x, 1'b1, tbl[1].exp, -1);
    if (bitq.size() >= b2 + 7) begin
      for (int i = 0; i < 7; i++)
        check($sformatf("restart_bit%0d", i), bitq[b2 + i], bitq[b1 + i]);
    end else begin
      check("restart_len", bitq.size(), b2 + 7);
    end

    // Long stream spans two LFSR periods.
    b1 = vcnt1; bd = dcnt1; b2 = ones1;
    x1 = 4'd8; start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    for (int k = 0; k < 80 && busy1; k++) begin
      @(posedge clk); #1;
    end
    check("long_idle", busy1, 0);
    @(posedge clk); #1;
    check("long_valid_cycles", vcnt1 - b1, 30);
    check("long_ones", ones1 - b2, 16);
    check("long_done_count", dcnt1 - bd, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
